keymatrix8x8_scan: RTL and testbench

- Scans an external 8x8 key/switch matrix: drives one column low at a time, reads the eight row lines, debounces every key and reports a 64-bit key state plus press/release events.
- Input-side counterpart of the LED matrix driver; uses the same bit numbering, index = col*8 + row.
- Feeds top-level control logic, e.g. seed entry or display-rate selection, through a 4-deep event FIFO with a valid/ready handshake.

---
 rtl/keymatrix8x8_scan.sv | 125 ++++++++++++
 tb/tb_keymatrix8x8_scan.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/keymatrix8x8_scan.sv
// 8x8 key matrix scanner: walks one active-low column at a time, debounces each key
// and reports press/release events through a 4-entry FIFO. Key index = col*8 + row.
module keymatrix8x8_scan #(
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        pReset,
  output logic [7:0]  colDrive,
  input  logic [7:0]  rowSense,
  output logic [63:0] keyState,
  output logic        evtValid,
  input  logic        evtReady,
  output logic        evtPress,
  output logic [5:0]  evtIndex,
  output logic        frameDone
);

  localparam int             DW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]     DB_LIM     = 4'(DEBOUNCE_SCANS);

  typedef enum logic {DWELL, UPDATE} state_t;

  state_t            state_q;
  logic [DW-1:0]     dwell_q;
  logic [2:0]        row_q, col_q;
  logic [7:0]        colDrive_q;
  logic [7:0]        sync1_q, sync2_q, smp_q;
  logic [63:0]       keyState_q;
  logic [63:0][2:0]  cnt_q;
  logic              frameDone_q;
  logic [3:0][6:0]   mem_q;
  logic [1:0]        head_q, tail_q;
  logic [2:0]        count_q;

  logic [5:0] key_idx;
  logic       smp_bit, differ, at_thresh, pop, full, push;
  logic [3:0] cnt_inc;
  logic [2:0] col_nxt;

  assign key_idx   = {col_q, row_q};
  assign smp_bit   = smp_q[row_q];
  assign differ    = smp_bit != keyState_q[key_idx];
  assign cnt_inc   = {1'b0, cnt_q[key_idx]} + 4'd1;
  assign at_thresh = cnt_inc == DB_LIM;
  assign pop       = (count_q != 3'd0) & evtReady;
  assign full      = count_q == 3'd4;
  // A flip that finds the FIFO full is simply retried on the next scan of this column.
  assign push      = (state_q == UPDATE) & differ & at_thresh & (~full | pop);
  assign col_nxt   = col_q + 3'd1;

  always_ff @(posedge clk) begin
    if (pReset) begin
      state_q     <= DWELL;
      dwell_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      colDrive_q  <= 8'hFE;
      sync1_q     <= 8'hFF;
      sync2_q     <= 8'hFF;
      smp_q       <= '0;
      keyState_q  <= '0;
      cnt_q       <= '0;
      frameDone_q <= 1'b0;
      mem_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      sync1_q     <= rowSense;
      sync2_q     <= sync1_q;
      frameDone_q <= 1'b0;
      unique case (state_q)
        DWELL: begin
          if (dwell_q == DWELL_LAST) begin
            smp_q   <= ~sync2_q;
            row_q   <= '0;
            state_q <= UPDATE;
          end else begin
            dwell_q <= dwell_q + DW'(1);
          end
        end
        UPDATE: begin
          if (!differ) begin
            cnt_q[key_idx] <= 3'd0;
          end else if (!at_thresh) begin
            cnt_q[key_idx] <= cnt_inc[2:0];
          end else if (push) begin
            keyState_q[key_idx] <= smp_bit;
            cnt_q[key_idx]      <= 3'd0;
          end
          if (row_q == 3'd7) begin
            col_q       <= col_nxt;
            colDrive_q  <= ~(8'd1 << col_nxt);
            dwell_q     <= '0;
            state_q     <= DWELL;
            frameDone_q <= (col_q == 3'd7);
          end else begin
            row_q <= row_q + 3'd1;
          end
        end
        default: state_q <= DWELL;
      endcase

      if (pop) head_q <= head_q + 2'd1;
      if (push) begin
        mem_q[tail_q] <= {smp_bit, key_idx};
        tail_q        <= tail_q + 2'd1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign colDrive            = colDrive_q;
  assign keyState            = keyState_q;
  assign frameDone           = frameDone_q;
  assign evtValid            = count_q != 3'd0;
  assign {evtPress, evtIndex} = mem_q[head_q];

endmodule

// File: tb/tb_keymatrix8x8_scan.sv
// Bench for keymatrix8x8_scan: a simulated key matrix plus a cycle-count/queue
// reference model checked every cycle, with directed scenarios and a random phase.
module tb_keymatrix8x8_scan;
  localparam int SD = 4, DB = 4, P = SD + 8, F = 8 * P;

  logic        clk = 1'b0, pReset = 1'b1;
  logic [7:0]  colDrive, rowSense;
  logic [63:0] keyState;
  logic        evtValid, evtReady = 1'b0, evtPress, frameDone;
  logic [5:0]  evtIndex;

  always #5 clk = ~clk;

  keymatrix8x8_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .pReset(pReset), .colDrive(colDrive), .rowSense(rowSense),
    .keyState(keyState), .evtValid(evtValid), .evtReady(evtReady),
    .evtPress(evtPress), .evtIndex(evtIndex), .frameDone(frameDone)
  );

  // Pressed keys pull their row low while their column is driven low.
  logic [63:0] mat = '0;
  always_comb begin
    rowSense = 8'hFF;
    for (int c = 0; c < 8; c++)
      if (colDrive[c] == 1'b0) rowSense = rowSense & ~mat[c*8 +: 8];
  end

  int nassert = 0, nfail = 0, t = 0, fd_cnt = 0, ready_mode = 1, ready_at = -1;
  logic [63:0] mks;
  int          mc [64];
  logic [6:0]  q [$];
  logic [6:0]  plog [$];
  logic        exp_fd;
  logic [6:0]  exp_drain [8] = '{7'h42, 7'h43, 7'h44, 7'h00, 7'h01, 7'h02, 7'h03, 7'h04};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int col, ph, row, k;
    logic do_push, mpop;
    logic [6:0] pe;
    logic [7:0] ecd;
    @(negedge clk);
    case (ready_mode)
      0:       evtReady = 1'b0;
      1:       evtReady = 1'b1;
      2:       evtReady = 1'($urandom_range(0, 1));
      default: evtReady = (t == ready_at);
    endcase
    if (evtValid && evtReady) plog.push_back({evtPress, evtIndex});
    col = (t / P) % 8; ph = t % P; exp_fd = 1'b0; do_push = 1'b0; pe = '0;
    mpop = (q.size() > 0) && evtReady;
    if (ph >= SD) begin
      row = ph - SD; k = col * 8 + row;
      if (mat[k] == mks[k]) mc[k] = 0;
      else if (mc[k] + 1 < DB) mc[k]++;
      else if (q.size() < 4 || mpop) begin
        mks[k] = mat[k]; mc[k] = 0; do_push = 1'b1; pe = {mat[k], 6'(k)};
      end
      exp_fd = (col == 7 && row == 7);
    end
    if (mpop) void'(q.pop_front());
    if (do_push) q.push_back(pe);
    @(posedge clk); #1;
    t++;
    if (frameDone) fd_cnt++;
    ecd = ~(8'd1 << ((t / P) % 8));
    chk("colDrive", colDrive, ecd);
    chk("keyState", keyState, mks);
    chk("evtValid", evtValid, q.size() > 0);
    chk("frameDone", frameDone, exp_fd);
    if (q.size() > 0) chk("head", {evtPress, evtIndex}, q[0]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    pReset = 1'b1; evtReady = 1'b0;
    @(posedge clk); #1;
    pReset = 1'b0;
    t = 0; mks = '0; fd_cnt = 0; q.delete();
    foreach (mc[i]) mc[i] = 0;
    chk("rst_colDrive", colDrive, 8'hFE);
    chk("rst_keyState", keyState, 64'd0);
    chk("rst_evtValid", evtValid, 1'b0);
    chk("rst_frameDone", frameDone, 1'b0);
    chk("rst_evtPress", evtPress, 1'b0);
    chk("rst_evtIndex", evtIndex, 6'd0);
  endtask

  initial begin
    do_reset();
    run(12);
    chk("col1_after12", colDrive, 8'hFD);
    run(F - 12);
    chk("wrap_FE", colDrive, 8'hFE);
    chk("frame_pulses", fd_cnt, 1);

    // Key 21 held four frames, then released four frames.
    plog.delete(); mat = '0; mat[21] = 1'b1;
    run(3 * F);
    chk("k21_not_yet", keyState[21], 1'b0);
    run(F);
    chk("k21_pressed", keyState[21], 1'b1);
    chk("k21_press_cnt", plog.size(), 1);
    chk("k21_press_evt", (plog.size() > 0) ? plog[0] : 7'h7F, 7'h55);
    plog.delete(); mat = '0;
    run(4 * F);
    chk("k21_released", keyState[21], 1'b0);
    chk("k21_rel_cnt", plog.size(), 1);
    chk("k21_rel_evt", (plog.size() > 0) ? plog[0] : 7'h7F, 7'h15);

    // Bounce: three frames pressed is not enough, and the count restarts.
    plog.delete(); mat[21] = 1'b1;
    run(3 * F);
    mat = '0;
    run(F);
    chk("bounce_state", keyState[21], 1'b0);
    chk("bounce_events", plog.size(), 0);
    mat[21] = 1'b1;
    run(3 * F);
    chk("bounce_restart", keyState[21], 1'b0);
    run(F);
    chk("bounce_then_hold", keyState[21], 1'b1);
    mat = '0;
    run(4 * F);

    // FIFO full with consumer stalled: key 4 waits until a slot opens.
    plog.delete(); ready_mode = 0; mat = 64'h1F;
    run(4 * F);
    chk("full_keys", keyState[4:0], 5'b01111);
    chk("full_valid", evtValid, 1'b1);
    run(F);
    chk("full_k4_held", keyState[4], 1'b0);
    ready_mode = 3; ready_at = t;
    run(1);
    ready_mode = 0;
    run(F - 1);
    chk("k4_after_pop", keyState[4], 1'b1);
    chk("pop_one_evt", (plog.size() > 0) ? plog[0] : 7'h7F, 7'h40);

    // Release while full; a single pop lines up with key 0's push.
    mat = '0;
    run(4 * F);
    plog.delete(); ready_mode = 3; ready_at = t + SD;
    run(F);
    chk("pushpop_cnt", plog.size(), 1);
    chk("pushpop_evt", (plog.size() > 0) ? plog[0] : 7'h7F, 7'h41);
    chk("pushpop_k0", keyState[0], 1'b0);
    plog.delete(); ready_mode = 1;
    run(2 * F);
    chk("drain_cnt", plog.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("drain_order", (plog.size() > i) ? plog[i] : 7'h7F, exp_drain[i]);

    // Reset in the middle of column 3's update with flips pending.
    ready_mode = 0; mat = 64'h0000_0000_0F00_0000;
    run(3 * F + 3 * P + SD + 2);
    chk("pre_rst_keys", keyState[27:24], 4'b0011);
    chk("pre_rst_valid", evtValid, 1'b1);
    do_reset();
    mat = '0; plog.delete(); ready_mode = 1;
    run(2 * F);
    chk("post_rst_events", plog.size(), 0);
    chk("post_rst_keys", keyState, 64'd0);

    // Random matrix changes at frame boundaries with a random consumer.
    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      mat = mat ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      run(F);
    end
    ready_mode = 1;
    run(2 * F);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
